vreg_group_arbiter: RTL and testbench
=====================================

// Module: vreg_group_arbiter
// PURPOSE
//  Shares one register-group address sequencer among NUM_REQ requesters (e.g. vs1/vs2 read, vd write).
//  Round-robin grants one request at a time, expands base vreg + vlmul into per-register addresses.
//  Streams the addresses to the VRF port under valid/ready, tagged with requester id and a last flag.
//  Sits between the issue stage and the vector register file address mux.
// PARAMETERS
//  ADDR_WIDTH  5                      vreg address width (32 vregs)
//  NUM_REQ     2                      number of requesters, >=2
//  ID_WIDTH    $clog2(NUM_REQ)        requester id width (derived, do not override)
// PORTS
//  clk        in   1                      clock
//  rst        in   1                      async reset, active-low
//  req        in   NUM_REQ                per-requester request, held until gnt
//  req_addr   in   NUM_REQ*ADDR_WIDTH     register-group address; slice i belongs to requester i
//  req_vlmul  in   NUM_REQ*3              vlmul per requester, slice i
//  gnt        out  NUM_REQ                one-hot acceptance pulse, Mealy, same cycle as accept
//  addr_valid out  1                      addr_out holds a valid vreg address
//  addr_ready in   1                      consumer accepts the beat this cycle
//  addr_out   out  ADDR_WIDTH             vreg address of the current beat
//  addr_id    out  ID_WIDTH               index of the requester that owns the beat
//  addr_last  out  1                      final beat of the group
//  idle       out  1                      high when in IDLE
// BEHAVIOUR
//  - One clock; async active-low reset; all flops clear on rst=0.
//  - Reset values: gnt=0, addr_valid=0, addr_out=0, addr_id=0, addr_last=0, idle=1, rr pointer=0.
//  - States: IDLE, BUSY.
//  - Accept window: IDLE, or BUSY with addr_valid & addr_ready & addr_last (back-to-back).
//    Without back-to-back accept: IDLE -> BUSY on accept; BUSY -> IDLE after the last beat handshakes.
//  - Arbitration: in the accept window, scan req from rr pointer upward, wrapping. First set bit i wins.
//    Winner gets gnt[i]=1 that cycle; slices i of req_addr/req_vlmul are latched; rr pointer <= (i+1) mod NUM_REQ.
//  - Accept cycle N -> first beat with addr_valid=1 in cycle N+1; 1 beat/cycle while addr_ready=1.
//  - Group expansion, latched at accept:
//    - vlmul 000..011: count = 1<<vlmul; base = (addr << vlmul) truncated to ADDR_WIDTH.
//      Low vlmul bits of base are 0, so base+count-1 never wraps.
//    - vlmul 1xx (fractional/reserved): count=1, base=addr.
//  - Beat k (0..count-1): addr_out = base+k; addr_last = (k==count-1).
//  - Backpressure: while addr_valid & ~addr_ready, addr_out/addr_id/addr_last are held stable.
//  - req/req_addr/req_vlmul changes after gnt have no effect on the group in flight.
//  - A requester still asserting req after gnt is treated as a new request.
//  - No req in accept window: gnt=0; BUSY exits to IDLE normally.
//  - Reset mid-group aborts it immediately; remaining beats are dropped and nothing is retained.
//  - idle = (state==IDLE); gnt is never asserted outside the accept window.
// STRUCTURE
//  - Shared package vrf_pkg:
//    - vlmul encodings (LMUL_1/2/4/8, fractional range).
//    - default ADDR_WIDTH.
//    - function group_count(vlmul) and function group_base(addr, vlmul).
//  - Sub-module vreg_group_counter: loads base/count and steps on advance.
//    Outputs cur addr and last; reuse it for every register-group walker.
//  - Top level holds the round-robin picker, FSM, id register and output hold logic.
// TESTING
//  1. req=01, addr0=3, vlmul0=010, ready=1 -> gnt=01 at N; addr 12,13,14,15 at N+1..N+4; last on 15; id=0; idle at N+5.
//  2. req=11 held, both vlmul=000, addr0=4, addr1=9 -> grants alternate 01,10,01 with back-to-back accepts.
//     Beats 4(id0),9(id1),4(id0) on consecutive cycles; idle never asserted.
//  3. vlmul=011, addr=2, ready toggling 1,0,0,1... -> addr 16..23 each held while ready=0; last only on 23; no beat skipped or repeated.
//  4. vlmul=101 (fractional), addr=7 -> single beat addr_out=7, addr_last=1; vlmul=100 identical.
//  5. vlmul=011, addr=5 -> base truncates to 8; beats 8..15.
//  6. rst=0 during beat 2 of an LMUL=4 group -> outputs zero asynchronously, idle=1, rr pointer=0.
//     After release, a new req grants normally.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared vector-register-file definitions: vlmul encodings, arbiter states and
// register-group expansion helpers used by every group walker.
package vrf_pkg;

   localparam int DEF_ADDR_WIDTH = 5;

   localparam logic [2:0] LMUL_1 = 3'b000;
   localparam logic [2:0] LMUL_2 = 3'b001;
   localparam logic [2:0] LMUL_4 = 3'b010;
   localparam logic [2:0] LMUL_8 = 3'b011;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Encodings 1xx are fractional/reserved and always occupy a single register.
   function automatic logic [3:0] group_count(input logic [2:0] vlmul);
      case (vlmul)
         LMUL_1:  return 4'd1;
         LMUL_2:  return 4'd2;
         LMUL_4:  return 4'd4;
         LMUL_8:  return 4'd8;
         default: return 4'd1;
      endcase
   endfunction

   function automatic logic [31:0] group_base(input logic [31:0] addr,
                                              input logic [2:0]  vlmul);
      case (vlmul)
         LMUL_1:  return addr;
         LMUL_2:  return addr << 1;
         LMUL_4:  return addr << 2;
         LMUL_8:  return addr << 3;
         default: return addr;
      endcase
   endfunction

endpackage

// File: rtl/vreg_group_counter.sv
// Register-group walker: loads a base address and beat count, then steps one
// register per advance and flags the final register of the group.
module vreg_group_counter
   import vrf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [3:0]            i_count,
   input  logic                  i_advance,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);

   logic [ADDR_WIDTH-1:0] r_cur;
   logic [3:0]            r_remain;

   // A load on the same cycle as the final advance starts the next group directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur    <= '0;
         r_remain <= '0;
      end else if (i_load) begin
         r_cur    <= i_base;
         r_remain <= i_count;
      end else if (i_advance && (r_remain != 4'd0)) begin
         r_cur    <= r_cur + 1'b1;
         r_remain <= r_remain - 4'd1;
      end
   end

   assign o_addr = r_cur;
   assign o_last = (r_remain == 4'd1);

endmodule

// File: rtl/vreg_group_arbiter.sv
// Round-robin arbiter that grants one register-group request at a time and
// streams its expanded vreg addresses to the VRF port under valid/ready.
module vreg_group_arbiter
   import vrf_pkg::*;
#(
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int NUM_REQ    = 2,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*3-1:0]          req_vlmul,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          addr_valid,
   input  logic                          addr_ready,
   output logic [ADDR_WIDTH-1:0]         addr_out,
   output logic [ID_WIDTH-1:0]           addr_id,
   output logic                          addr_last,
   output logic                          idle
);

   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic [ID_WIDTH-1:0]   r_rr;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ID_WIDTH-1:0]   w_pick;
   logic                  w_found;
   logic                  w_hs;
   logic                  w_win;
   logic                  w_accept;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [2:0]            w_sel_vlmul;
   logic [ADDR_WIDTH-1:0] w_base;
   logic [3:0]            w_count;
   logic [ADDR_WIDTH-1:0] w_cnt_addr;
   logic                  w_cnt_last;

   // Round-robin scan starting at the pointer and wrapping past NUM_REQ-1.
   always_comb begin
      int w_idx;
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_rr) + k) % NUM_REQ;
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = ID_WIDTH'(w_idx);
         end
      end
   end

   assign w_sel_addr  = req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_vlmul = req_vlmul[int'(w_pick)*3 +: 3];
   assign w_base      = ADDR_WIDTH'(group_base(32'(w_sel_addr), w_sel_vlmul));
   assign w_count     = group_count(w_sel_vlmul);

   assign w_hs  = (r_state == ST_BUSY) && addr_ready;
   assign w_win = (r_state == ST_IDLE) || (w_hs && w_cnt_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      gnt         = '0;
      addr_valid  = 1'b0;
      idle        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            idle = 1'b1;
            if (w_found) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            addr_valid = 1'b1;
            if (w_win) begin
               w_accept    = w_found;
               w_state_nxt = w_found ? ST_BUSY : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_accept) begin
         gnt[w_pick] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr <= '0;
         r_id <= '0;
      end else if (w_accept) begin
         r_rr <= (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + 1'b1;
         r_id <= w_pick;
      end
   end

   vreg_group_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_accept),
      .i_base    (w_base),
      .i_count   (w_count),
      .i_advance (w_hs),
      .o_addr    (w_cnt_addr),
      .o_last    (w_cnt_last)
   );

   assign addr_out  = w_cnt_addr;
   assign addr_id   = r_id;
   assign addr_last = w_cnt_last;

endmodule

// File: tb/tb_vreg_group_arbiter.sv
// Directed bench for vreg_group_arbiter: hand-computed grants and beat streams
// covering expansion, round-robin, backpressure, fractional vlmul and reset.
module tb_vreg_group_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [9:0] req_addr;
   logic [5:0] req_vlmul;
   logic [1:0] gnt;
   logic       addr_valid;
   logic       addr_ready;
   logic [4:0] addr_out;
   logic [0:0] addr_id;
   logic       addr_last;
   logic       idle;

   int checks   = 0;
   int failures = 0;

   vreg_group_arbiter #(
      .ADDR_WIDTH (5),
      .NUM_REQ    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_addr   (req_addr),
      .req_vlmul  (req_vlmul),
      .gnt        (gnt),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr_out   (addr_out),
      .addr_id    (addr_id),
      .addr_last  (addr_last),
      .idle       (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input int a, input int id, input int last);
      chk({tag, "_valid"}, 32'(addr_valid), 1);
      chk({tag, "_addr"},  32'(addr_out),   32'(a));
      chk({tag, "_id"},    32'(addr_id),    32'(id));
      chk({tag, "_last"},  32'(addr_last),  32'(last));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [2:0] vl);
      req_addr[i*5 +: 5]  = a;
      req_vlmul[i*3 +: 3] = vl;
   endtask

   initial begin
      logic [3:0] pat;
      int         k;
      logic       hs;
      pat        = 4'b1001;
      rst        = 1'b1;
      req        = 2'b00;
      req_addr   = '0;
      req_vlmul  = '0;
      addr_ready = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_gnt",   32'(gnt),        0);
      chk("rst_valid", 32'(addr_valid), 0);
      chk("rst_addr",  32'(addr_out),   0);
      chk("rst_id",    32'(addr_id),    0);
      chk("rst_last",  32'(addr_last),  0);
      chk("rst_idle",  32'(idle),       1);
      @(posedge clk);
      #1 rst = 1'b1;

      // Two requesters held: back-to-back grants 01,10,01 with beats 4,9,4.
      set_req(0, 5'd4, 3'b000);
      set_req(1, 5'd9, 3'b000);
      req = 2'b11;
      #1;
      chk("t2_gnt0", 32'(gnt), 32'b01);
      chk("t2_idle0", 32'(idle), 1);
      tick(); #1;
      beat("t2_b0", 4, 0, 1);
      chk("t2_gnt1", 32'(gnt), 32'b10);
      chk("t2_idle1", 32'(idle), 0);
      tick(); #1;
      beat("t2_b1", 9, 1, 1);
      chk("t2_gnt2", 32'(gnt), 32'b01);
      tick(); req = 2'b00; #1;
      beat("t2_b2", 4, 0, 1);
      chk("t2_gnt3", 32'(gnt), 0);
      chk("t2_idle2", 32'(idle), 0);
      tick(); #1;
      chk("t2_idle_end", 32'(idle), 1);
      chk("t2_valid_end", 32'(addr_valid), 0);

      // LMUL=4, addr 3 -> beats 12..15.
      set_req(0, 5'd3, 3'b010);
      req = 2'b01;
      #1;
      chk("t1_gnt", 32'(gnt), 32'b01);
      tick(); req = 2'b00; #1;
      beat("t1_b0", 12, 0, 0);
      for (int i = 1; i < 4; i++) begin
         tick(); #1;
         beat("t1_b", 12 + i, 0, (i == 3) ? 1 : 0);
      end
      chk("t1_gnt_last", 32'(gnt), 0);
      tick(); #1;
      chk("t1_idle", 32'(idle), 1);
      chk("t1_valid", 32'(addr_valid), 0);

      // LMUL=8, addr 2 -> beats 16..23 under ready pattern 1,0,0,1.
      set_req(0, 5'd2, 3'b011);
      req = 2'b01;
      #1;
      chk("t3_gnt", 32'(gnt), 32'b01);
      tick(); req = 2'b00;
      k = 0;
      for (int c = 0; c < 40; c++) begin
         addr_ready = pat[c % 4];
         #1;
         beat("t3_b", 16 + k, 0, (k == 7) ? 1 : 0);
         hs = addr_ready;
         tick();
         if (hs) k++;
         if (k == 8) break;
      end
      addr_ready = 1'b1;
      #1;
      chk("t3_beats", 32'(k), 8);
      chk("t3_idle", 32'(idle), 1);

      // Fractional vlmul=101 on requester 1, then vlmul=100 on requester 0.
      set_req(1, 5'd7, 3'b101);
      req = 2'b10;
      #1;
      chk("t4a_gnt", 32'(gnt), 32'b10);
      tick(); req = 2'b00; #1;
      beat("t4a_b", 7, 1, 1);
      tick(); #1;
      chk("t4a_idle", 32'(idle), 1);
      set_req(0, 5'd7, 3'b100);
      req = 2'b01;
      #1;
      chk("t4b_gnt", 32'(gnt), 32'b01);
      tick(); req = 2'b00; #1;
      beat("t4b_b", 7, 0, 1);
      tick(); #1;
      chk("t4b_idle", 32'(idle), 1);

      // LMUL=8, addr 5: 40 truncates to 8 -> beats 8..15.
      set_req(1, 5'd5, 3'b011);
      req = 2'b10;
      #1;
      chk("t5_gnt", 32'(gnt), 32'b10);
      tick(); req = 2'b00; #1;
      beat("t5_b0", 8, 1, 0);
      for (int i = 1; i < 8; i++) begin
         tick(); #1;
         beat("t5_b", 8 + i, 1, (i == 7) ? 1 : 0);
      end
      tick(); #1;
      chk("t5_idle", 32'(idle), 1);

      // Reset during beat 2 of an LMUL=4 group (base 4): beat 2 is addr 6.
      set_req(0, 5'd1, 3'b010);
      req = 2'b01;
      #1;
      chk("t6_gnt", 32'(gnt), 32'b01);
      tick(); req = 2'b00; #1;
      beat("t6_b0", 4, 0, 0);
      tick(); #1;
      beat("t6_b1", 5, 0, 0);
      tick(); #1;
      beat("t6_b2", 6, 0, 0);
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(addr_valid), 0);
      chk("t6_rst_addr",  32'(addr_out),   0);
      chk("t6_rst_last",  32'(addr_last),  0);
      chk("t6_rst_id",    32'(addr_id),    0);
      chk("t6_rst_idle",  32'(idle),       1);
      @(posedge clk);
      #1 rst = 1'b1;
      set_req(0, 5'd10, 3'b000);
      set_req(1, 5'd20, 3'b000);
      req = 2'b11;
      #1;
      chk("t6_post_gnt", 32'(gnt), 32'b01);
      tick(); req = 2'b00; #1;
      beat("t6_post_b", 10, 0, 1);
      tick(); #1;
      chk("t6_post_idle", 32'(idle), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
